// File: rtl/impact_wl_sequencer.sv
// Word-line sequencer for a 10-row SRAM bank: receives a serial 16-bit command,
// pulses one word line per row, and captures the bitline into RES.
module impact_wl_sequencer (
    input  logic       C,
    input  logic       R,
    input  logic       SI,
    input  logic       SE,
    input  logic       BL,
    input  logic       BLb,
    output logic [9:0] WL,
    output logic [9:0] RES,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       INV
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        se_q, se_d;
    logic        start_q, start_d;
    logic [3:0]  row_q, row_d;
    logic [7:0]  pw_q, pw_d;
    logic        sweep_q, sweep_d;
    logic [8:0]  pcnt_q, pcnt_d;
    logic        gap_q, gap_d;
    logic [9:0]  wl_q, wl_d;
    logic [9:0]  res_q, res_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        inv_q, inv_d;

    // Serial frame capture, command decode and row sequencing.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        se_d    = se_q;
        start_d = start_q;
        row_d   = row_q;
        pw_d    = pw_q;
        sweep_d = sweep_q;
        pcnt_d  = pcnt_q;
        gap_d   = gap_q;
        res_d   = res_q;
        done_d  = 1'b0;
        err_d   = err_q;
        inv_d   = inv_q;

        // The latch edge only queues the command; the FSM leaves IDLE one edge later.
        if (busy_q || start_q) begin
            cnt_d = 5'd0;
            se_d  = 1'b0;
        end else if (SE) begin
            sr_d  = {sr_q[14:0], SI};
            cnt_d = (cnt_q == 5'd16) ? 5'd16 : cnt_q + 5'd1;
            se_d  = 1'b1;
        end else if (se_q) begin
            se_d  = 1'b0;
            cnt_d = 5'd0;
            if (cnt_q != 5'd16) begin
                err_d = 1'b1;
            end else begin
                case (sr_q[15:14])
                    2'b00: begin
                        err_d = err_q;
                    end
                    2'b01: begin
                        if (sr_q[13:10] > 4'd9) begin
                            err_d = 1'b1;
                        end else begin
                            start_d = 1'b1;
                            row_d   = sr_q[13:10];
                            pw_d    = sr_q[9:2];
                            sweep_d = 1'b0;
                            err_d   = 1'b0;
                            inv_d   = 1'b0;
                        end
                    end
                    2'b10: begin
                        start_d = 1'b1;
                        row_d   = 4'd0;
                        pw_d    = sr_q[9:2];
                        sweep_d = 1'b1;
                        err_d   = 1'b0;
                        inv_d   = 1'b0;
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end
        end else begin
            se_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d = SETUP;
                    start_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = PULSE;
                pcnt_d  = 9'd0;
            end
            PULSE: begin
                if (pcnt_q == {1'b0, pw_q}) begin
                    state_d    = GAP;
                    gap_d      = 1'b0;
                    res_d[row_q] = BL;
                    if (BL == BLb) begin
                        inv_d = 1'b1;
                    end else begin
                        inv_d = inv_q;
                    end
                end else begin
                    pcnt_d = pcnt_q + 9'd1;
                end
            end
            GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (sweep_q && (row_q != 4'd9)) begin
                    state_d = SETUP;
                    row_d   = row_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wl_d   = (state_d == PULSE) ? (10'd1 << row_d) : 10'd0;
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            sr_q    <= 16'd0;
            cnt_q   <= 5'd0;
            se_q    <= 1'b0;
            start_q <= 1'b0;
            row_q   <= 4'd0;
            pw_q    <= 8'd0;
            sweep_q <= 1'b0;
            pcnt_q  <= 9'd0;
            gap_q   <= 1'b0;
            wl_q    <= 10'd0;
            res_q   <= 10'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            se_q    <= se_d;
            start_q <= start_d;
            row_q   <= row_d;
            pw_q    <= pw_d;
            sweep_q <= sweep_d;
            pcnt_q  <= pcnt_d;
            gap_q   <= gap_d;
            wl_q    <= wl_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            inv_q   <= inv_d;
        end
    end

    assign WL   = wl_q;
    assign RES  = res_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign INV  = inv_q;

endmodule

// File: tb/tb_impact_wl_sequencer.sv
// Directed self-checking bench for impact_wl_sequencer; cycle index i counts
// edges after the command latch edge E0, sampled on the falling edge.
module tb_impact_wl_sequencer;

    logic       C, R, SI, SE, bl_r, blb_r, bank_model;
    logic       BL, BLb;
    logic [9:0] WL, RES;
    logic       BUSY, DONE, ERR, INV;
    int         checks, errors;

    // Bank model for sweeps: even rows read 1, odd rows read 0.
    assign BL  = bank_model ? |(WL & 10'h155) : bl_r;
    assign BLb = bank_model ? ~BL : blb_r;

    impact_wl_sequencer dut (
        .C(C), .R(R), .SI(SI), .SE(SE), .BL(BL), .BLb(BLb),
        .WL(WL), .RES(RES), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .INV(INV)
    );

    always #5 C = ~C;

    function automatic logic [15:0] rd_frame(input logic [3:0] row, input logic [7:0] pw);
        return {2'b01, row, pw, 2'b00};
    endfunction

    task automatic send(input logic [19:0] f, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            @(negedge C);
            SE = 1'b1;
            SI = f[k];
        end
        @(negedge C);
        SE = 1'b0;
        SI = 1'b0;
        @(posedge C);
        @(negedge C);
    endtask

    task automatic cycle();
        @(posedge C);
        @(negedge C);
    endtask

    task automatic test_reset();
        R = 1'b1;
        repeat (3) cycle();
        checks += 6;
        if (WL !== 10'd0)   begin errors++; $display("FAIL reset_wl got %h want 000", WL); end
        if (RES !== 10'd0)  begin errors++; $display("FAIL reset_res got %h want 000", RES); end
        if (BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        if (DONE !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
        if (ERR !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
        if (INV !== 1'b0)   begin errors++; $display("FAIL reset_inv got %b want 0", INV); end
        R = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_read();
        logic [9:0] exp_wl;
        bl_r = 1'b1; blb_r = 1'b0;
        send({4'h0, rd_frame(4'd5, 8'd3)}, 16);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            exp_wl = (i >= 2 && i <= 5) ? 10'h020 : 10'h000;
            checks += 3;
            if (WL !== exp_wl) begin errors++; $display("FAIL read_wl i=%0d got %h want %h", i, WL, exp_wl); end
            if (DONE !== (i == 8)) begin errors++; $display("FAIL read_done i=%0d got %b want %b", i, DONE, i == 8); end
            if (BUSY !== (i >= 1 && i <= 7)) begin errors++; $display("FAIL read_busy i=%0d got %b", i, BUSY); end
        end
        checks += 3;
        if (RES !== 10'h020) begin errors++; $display("FAIL read_res got %h want 020", RES); end
        if (INV !== 1'b0)    begin errors++; $display("FAIL read_inv got %b want 0", INV); end
        if (ERR !== 1'b0)    begin errors++; $display("FAIL read_err got %b want 0", ERR); end
    endtask

    task automatic test_sweep();
        logic [9:0] exp_wl;
        int         dones;
        dones = 0;
        bank_model = 1'b1;
        send(20'h08000, 16);
        for (int i = 1; i <= 46; i++) begin
            cycle();
            exp_wl = (i >= 2 && i <= 38 && ((i - 2) % 4) == 0) ? (10'd1 << ((i - 2) / 4)) : 10'd0;
            if (DONE === 1'b1) dones++;
            checks += 2;
            if (WL !== exp_wl) begin errors++; $display("FAIL sweep_wl i=%0d got %h want %h", i, WL, exp_wl); end
            if (DONE !== (i == 41)) begin errors++; $display("FAIL sweep_done i=%0d got %b want %b", i, DONE, i == 41); end
        end
        checks += 2;
        if (RES !== 10'h155) begin errors++; $display("FAIL sweep_res got %h want 155", RES); end
        if (dones != 1)      begin errors++; $display("FAIL sweep_done_count got %0d want 1", dones); end
        bank_model = 1'b0;
    endtask

    task automatic test_bad_frames();
        send(20'h00ABC, 12);
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", ERR); end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            checks++;
            if (BUSY !== 1'b0 || WL !== 10'd0) begin errors++; $display("FAIL short_idle i=%0d busy %b wl %h want 0 000", i, BUSY, WL); end
        end
        send({4'h0, rd_frame(4'd1, 8'd0)}, 16);
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL valid_clears_err got %b want 0", ERR); end
        repeat (10) cycle();
        send(20'h0C000, 16);
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL op11_err got %b want 1", ERR); end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            checks++;
            if (BUSY !== 1'b0 || WL !== 10'd0) begin errors++; $display("FAIL op11_idle i=%0d busy %b wl %h", i, BUSY, WL); end
        end
        send({4'h0, rd_frame(4'd1, 8'd0)}, 16);
        repeat (10) cycle();
        send({4'h0, rd_frame(4'd12, 8'd0)}, 16);
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL row12_err got %b want 1", ERR); end
        for (int i = 1; i <= 10; i++) begin
            cycle();
            checks++;
            if (BUSY !== 1'b0 || WL !== 10'd0) begin errors++; $display("FAIL row12_idle i=%0d busy %b wl %h", i, BUSY, WL); end
        end
        send(20'h00000, 16);
        for (int i = 1; i <= 8; i++) begin
            cycle();
            checks++;
            if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL nop_idle i=%0d busy %b done %b", i, BUSY, DONE); end
        end
        checks++;
        if (ERR !== 1'b1) begin errors++; $display("FAIL nop_keeps_err got %b want 1", ERR); end
    endtask

    task automatic test_bitline_fault();
        bl_r = 1'b1; blb_r = 1'b1;
        send({4'h0, rd_frame(4'd2, 8'd1)}, 16);
        repeat (12) cycle();
        checks += 2;
        if (INV !== 1'b1)    begin errors++; $display("FAIL fault_inv got %b want 1", INV); end
        if (RES[2] !== 1'b1) begin errors++; $display("FAIL fault_res2 got %b want 1", RES[2]); end
        blb_r = 1'b0;
        send({4'h0, rd_frame(4'd2, 8'd0)}, 16);
        checks++;
        if (INV !== 1'b0) begin errors++; $display("FAIL fault_inv_clear got %b want 0", INV); end
        repeat (10) cycle();
        checks++;
        if (INV !== 1'b0) begin errors++; $display("FAIL fault_inv_stays_clear got %b want 0", INV); end
    endtask

    task automatic test_overlong();
        logic [9:0] exp_wl;
        bl_r = 1'b0; blb_r = 1'b1;
        send({4'hF, rd_frame(4'd7, 8'd0)}, 20);
        checks++;
        if (ERR !== 1'b0) begin errors++; $display("FAIL long_err got %b want 0", ERR); end
        for (int i = 1; i <= 10; i++) begin
            cycle();
            exp_wl = (i == 2) ? 10'h080 : 10'h000;
            checks += 2;
            if (WL !== exp_wl) begin errors++; $display("FAIL long_wl i=%0d got %h want %h", i, WL, exp_wl); end
            if (DONE !== (i == 5)) begin errors++; $display("FAIL long_done i=%0d got %b want %b", i, DONE, i == 5); end
        end
        checks++;
        if (RES[7] !== 1'b0) begin errors++; $display("FAIL long_res7 got %b want 0", RES[7]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f;
        logic [9:0]  exp_wl;
        f = rd_frame(4'd0, 8'd0);
        send({4'h0, rd_frame(4'd4, 8'd30)}, 16);
        for (int i = 1; i <= 55; i++) begin
            cycle();
            exp_wl = (i >= 2 && i <= 32) ? 10'h010 : 10'h000;
            checks += 2;
            if (WL !== exp_wl) begin errors++; $display("FAIL busy_wl i=%0d got %h want %h", i, WL, exp_wl); end
            if (DONE !== (i == 35)) begin errors++; $display("FAIL busy_done i=%0d got %b want %b", i, DONE, i == 35); end
            if (i >= 2 && i <= 17) begin
                SE = 1'b1;
                SI = f[17 - i];
            end else begin
                SE = 1'b0;
                SI = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        send({4'h0, rd_frame(4'd3, 8'd10)}, 16);
        repeat (4) cycle();
        checks++;
        if (WL !== 10'h008) begin errors++; $display("FAIL mid_wl_before got %h want 008", WL); end
        #2 R = 1'b1;
        #1;
        checks += 3;
        if (WL !== 10'd0)  begin errors++; $display("FAIL mid_wl_async got %h want 000", WL); end
        if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b want 0", BUSY); end
        if (RES !== 10'd0) begin errors++; $display("FAIL mid_res_async got %h want 000", RES); end
        @(negedge C);
        R = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            cycle();
            checks++;
            if (DONE !== 1'b0 || WL !== 10'd0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL mid_after i=%0d done %b wl %h busy %b want 0 000 0", i, DONE, WL, BUSY);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        C = 1'b0; R = 1'b1; SI = 1'b0; SE = 1'b0;
        bl_r = 1'b0; blb_r = 1'b1; bank_model = 1'b0;
        test_reset();
        test_read();
        test_sweep();
        test_bad_frames();
        test_bitline_fault();
        test_overlong();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/impact_wl_sequencer.md
IMPACT_WL_SEQUENCER -- requirements
Module: impact_wl_sequencer

Interface
REQ-001 SHALL have ports exactly: C  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have: R  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: SI  in  1  serial command data, sampled on C rising edge while SE=1.
REQ-004 SHALL have: SE  in  1  shift enable; frames one command.
REQ-005 SHALL have: BL, BLb  in  1 each  bitline and complement from the SRAM bank.
REQ-006 SHALL have: WL  out  10  one-hot word-line select driven into the bank word decoder.
REQ-007 SHALL have: RES  out  10  read results, bit n = BL captured for row n.
REQ-008 SHALL have: BUSY, DONE, ERR, INV  out  1 each  status flags.

Function
REQ-009 SHALL shift SI into a 16-bit register, MSB first, on every edge with SE=1 and BUSY=0; the bit counter saturates at 16.
REQ-010 SHALL decode the frame as [15:14] OP, [13:10] ROW, [9:2] PW, [1:0] ignored.
REQ-011 SHALL latch the command on the first edge where SE=0 after SE=1, provided the counter is 16; the frame uses the last 16 bits shifted.
REQ-012 SHALL discard the frame on that edge if the counter is below 16, set ERR and clear the counter.
REQ-013 SHALL ignore SE and SI while BUSY=1; the counter stays 0.
REQ-014 SHALL treat OP 00 as NOP: no BUSY and no DONE.
REQ-015 SHALL treat OP 11, and OP 01 with ROW>9, as invalid: set ERR, no WL activity, no DONE.
REQ-016 SHALL clear ERR and INV on latching any valid OP 01 or OP 10 command.
REQ-017 SHALL implement FSM states IDLE, SETUP, PULSE, GAP.
REQ-018 SHALL follow these transitions: IDLE->SETUP on valid latch (edge E0); SETUP->PULSE after 1 cycle; PULSE->GAP after PW+1 cycles; GAP->next after 2 cycles.
REQ-019 SHALL assert WL[row] only in PULSE; in all other states WL=0; WL is never multi-hot.
REQ-020 SHALL, for PW=0, produce a 1-cycle pulse; for PW=255, produce a 256-cycle pulse (9-bit counter, no wrap).
REQ-021 SHALL, on the PULSE->GAP edge, capture BL into RES[row]; if BL==BLb at that edge it sets INV (sticky).
REQ-022 SHALL, for OP 01 (READ), go GAP->IDLE and update only RES[ROW].
REQ-023 SHALL, for OP 10 (SWEEP), ignore ROW and run rows 0..9 in order, each as SETUP/PULSE/GAP; after row 9, GAP->IDLE; all RES bits are overwritten.
REQ-024 SHALL hold BUSY=1 from the edge after E0 until the GAP->IDLE edge.
REQ-025 SHALL pulse DONE high for exactly one cycle after the GAP->IDLE edge.
REQ-026 SHALL give READ a total latency of E0 to DONE rising of PW+5 edges.

Reset
REQ-027 SHALL, while R=1, immediately force WL=0, RES=0, BUSY=0, DONE=0, ERR=0, INV=0, state IDLE, shift register and counter 0, regardless of the current state.
REQ-028 SHALL produce no DONE after R deasserts mid-operation; the aborted command is lost.

Verification
REQ-029 SHALL cover READ: frame OP=01, ROW=5, PW=3, BL=1, BLb=0 -> WL=0x020 for exactly 4 cycles starting 2 edges after E0, RES[5]=1, DONE at E0+8, INV=0.
REQ-030 SHALL cover SWEEP: OP=10, PW=0, BL toggling per row (1,0,1...) -> WL walks 0x001..0x200, each row high for 1 cycle, RES=0x155, DONE once.
REQ-031 SHALL cover bad frames: 12-bit frame -> ERR=1, no WL, no BUSY; then OP=11 -> ERR=1; then OP=01, ROW=12 -> ERR=1, WL stays 0.
REQ-032 SHALL cover bitline fault: READ with BL=BLb=1 at capture -> INV=1, RES[row]=1; the next valid command clears INV.
REQ-033 SHALL cover overlong frame and busy ignore: 20 bits shifted -> the last 16 are used; shifting during BUSY -> no effect and no new command.
REQ-034 SHALL cover reset mid-pulse: R asserted with WL=0x008 -> WL=0 and BUSY=0 asynchronously, no DONE after release.
